// File: rtl/fu_config_sequencer.sv
// fu_config_sequencer: holds a small config program and issues it to a
// functional unit one word at a time over the on_off/ack handshake.
// Each entry is issued in RUN, and the ack is released in DRAIN before the
// sequencer advances.
// Optional build macro: FU_SEQ_TIMEOUT_EN adds a bounded ack wait in RUN.
module fu_config_sequencer #(
   parameter int cfg_width      = 16,
   parameter int depth          = 16,
   parameter int addr_w         = $clog2(depth),
   parameter int timeout_cycles = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_we,
   input  logic [addr_w-1:0]    cfg_waddr,
   input  logic [cfg_width-1:0] cfg_wdata,
   input  logic [addr_w:0]      num_entries,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 loop_en,
   input  logic                 ack,
   output logic [cfg_width-1:0] config_out,
   output logic                 on_off,
   output logic [addr_w-1:0]    pc,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout_err
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [addr_w:0]   depth_w   = (addr_w + 1)'(depth);
   localparam logic [addr_w-1:0] depth_max = addr_w'(depth - 1);

   state_t               state_reg, state_next;
   logic [cfg_width-1:0] mem [depth];
   logic [addr_w-1:0]    pc_reg, pc_next;
   logic [addr_w-1:0]    last_reg, last_next;
   logic [addr_w-1:0]    pc_inc;
   logic [addr_w-1:0]    last_sel;
   logic [cfg_width-1:0] config_reg, config_next;
   logic                 on_off_reg, on_off_next;
   logic                 done_reg, done_next;
   logic                 timeout_reg, timeout_next;
   logic                 timeout_hit;
   logic                 at_last;

   // Program length is clamped to the memory depth; last_sel is the index
   // of the final entry (only meaningful when num_entries is non-zero).
   assign last_sel = (num_entries > depth_w) ? depth_max
                                             : addr_w'(num_entries - 1'b1);
   assign pc_inc   = pc_reg + 1'b1;
   assign at_last  = (pc_reg == last_reg);

`ifdef FU_SEQ_TIMEOUT_EN
   localparam int               tmo_w    = $clog2(timeout_cycles + 1);
   localparam logic [tmo_w-1:0] tmo_last = tmo_w'(timeout_cycles - 1);

   logic [tmo_w-1:0] wait_cnt_reg, wait_cnt_next;

   // Ack wait counter: cleared on every entry to RUN, counts RUN cycles without ack.
   always_comb begin
      wait_cnt_next = wait_cnt_reg;
      if (state_next == RUN && state_reg != RUN)
         wait_cnt_next = '0;
      else if (state_reg == RUN && !ack)
         wait_cnt_next = wait_cnt_reg + 1'b1;
   end

   // Wait counter register.
   always_ff @(posedge clk) begin
      if (reset)
         wait_cnt_reg <= '0;
      else
         wait_cnt_reg <= wait_cnt_next;
   end

   // The cycle that would bring the count up to timeout_cycles aborts the program.
   assign timeout_hit = (state_reg == RUN) && !ack && (wait_cnt_reg == tmo_last);
`else
   logic timeout_unused;

   // No ack timeout in this build: RUN waits for ack indefinitely.
   assign timeout_hit    = 1'b0;
   assign timeout_unused = timeout_cycles[0];
`endif

   // Config memory: writes land only while idle so a running program never changes.
   always_ff @(posedge clk) begin
      if (cfg_we && state_reg == IDLE)
         mem[cfg_waddr] <= cfg_wdata;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         pc_reg      <= '0;
         last_reg    <= '0;
         config_reg  <= '0;
         on_off_reg  <= 1'b0;
         done_reg    <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         last_reg    <= last_next;
         config_reg  <= config_next;
         on_off_reg  <= on_off_next;
         done_reg    <= done_next;
         timeout_reg <= timeout_next;
      end
   end

   // Next-state logic; stop outranks ack, and DRAIN waits for ack to fall.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (start && num_entries != '0)
               state_next = RUN;
         end
         RUN: begin
            if (stop || timeout_hit)
               state_next = IDLE;
            else if (ack)
               state_next = DRAIN;
         end
         DRAIN: begin
            if (stop)
               state_next = IDLE;
            else if (!ack)
               state_next = (at_last && !loop_en) ? IDLE : RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   // Next values of the registered outputs for each state transition.
   always_comb begin
      pc_next      = pc_reg;
      last_next    = last_reg;
      config_next  = config_reg;
      on_off_next  = on_off_reg;
      done_next    = 1'b0;
      timeout_next = timeout_reg;
      unique case (state_reg)
         IDLE: begin
            on_off_next = 1'b0;
            if (start) begin
               if (num_entries == '0) begin
                  done_next = 1'b1;
               end else begin
                  last_next    = last_sel;
                  pc_next      = '0;
                  config_next  = mem[0];
                  on_off_next  = 1'b1;
                  timeout_next = 1'b0;
               end
            end
         end
         RUN: begin
            if (stop) begin
               on_off_next = 1'b0;
            end else if (timeout_hit) begin
               on_off_next  = 1'b0;
               timeout_next = 1'b1;
            end else if (ack) begin
               on_off_next = 1'b0;
            end
         end
         DRAIN: begin
            on_off_next = 1'b0;
            if (!stop && !ack) begin
               if (!at_last) begin
                  pc_next     = pc_inc;
                  config_next = mem[pc_inc];
                  on_off_next = 1'b1;
               end else if (loop_en) begin
                  pc_next     = '0;
                  config_next = mem[0];
                  on_off_next = 1'b1;
               end else begin
                  done_next = 1'b1;
               end
            end
         end
         default: on_off_next = 1'b0;
      endcase
   end

   assign config_out  = config_reg;
   assign on_off      = on_off_reg;
   assign pc          = pc_reg;
   assign busy        = (state_reg != IDLE);
   assign done        = done_reg;
   assign timeout_err = timeout_reg;

endmodule

// File: doc/fu_config_sequencer.md
# fu_config_sequencer

Issue controller that drives a functional unit's `config_in` / `on_off` inputs and consumes its `ack`. It holds a small config program, issues one config word at a time, and waits for the FU to acknowledge completion before advancing. It sits between the tile's config loader and an `adder_fu`-style FU, and is the initiator side of the FU's on_off/ack handshake.

## Interface
- `cfg_width`, 16, width of one config word (matches FU `config_in`)
- `depth`, 16, number of config entries (power of two, ≥ 2)
- `addr_w`, $clog2(depth), entry address width
- `timeout_cycles`, 64, max cycles to wait for ack (used only with the timeout macro)

- `clk`  input  1  single clock, all logic on posedge
- `reset`  input  1  synchronous, active-high
- `cfg_we`  input  1  write strobe for config memory
- `cfg_waddr`  input  addr_w  write address
- `cfg_wdata`  input  cfg_width  write data
- `num_entries`  input  addr_w+1  program length, latched at start
- `start`  input  1  begin program (sampled in IDLE only)
- `stop`  input  1  abort program
- `loop_en`  input  1  restart at entry 0 after last entry
- `ack`  input  1  FU completion, level-sensitive
- `config_out`  output  cfg_width  registered config word to FU
- `on_off`  output  1  registered enable to FU
- `pc`  output  addr_w  index of current entry
- `busy`  output  1  high outside IDLE
- `done`  output  1  one-cycle pulse at program completion
- `timeout_err`  output  1  sticky timeout flag

## Operation
- States: IDLE, RUN, DRAIN.
- Reset: state IDLE; `config_out`=0, `on_off`=0, `pc`=0, `busy`=0, `done`=0, `timeout_err`=0. Memory contents are not reset.
- Memory writes take effect only in IDLE. Writes while `busy` are dropped.
- IDLE + `start`, `num_entries`≥1: latch length, `pc`←0, `config_out`←mem[0], `on_off`←1, go to RUN. Clear `timeout_err`.
- IDLE + `start`, `num_entries`=0: pulse `done` the next cycle, stay in IDLE, no issue.
- IDLE + `start`, `num_entries`>depth: clamp the length to `depth`.
- RUN: hold `on_off`=1 and `config_out` until `ack` is sampled high. Then `on_off`←0 and go to DRAIN.
- DRAIN: `on_off`=0 and `config_out` held; wait for `ack`=0. This prevents a stale ack from completing the next entry. On `ack`=0:
  - `pc` not last: `pc`←`pc`+1, load mem[pc+1], `on_off`←1, go to RUN.
  - `pc` last, `loop_en`=1: `pc`←0, load mem[0], `on_off`←1, go to RUN. No `done`.
  - `pc` last, `loop_en`=0: pulse `done`, go to IDLE. `config_out` keeps the last word.
- `stop` in RUN or DRAIN: next cycle `on_off`=0, state IDLE, no `done`. `stop` has priority over `ack`. `start` while busy is ignored.
- `pc` wraps only through the loop path, never by arithmetic overflow.

## Timing
- Start to first `on_off` high: 1 cycle (registered).
- `ack` high to `on_off` low: 1 cycle.
- `ack` low in DRAIN to next `on_off` high: 1 cycle.
- Minimum per entry: 2 cycles (ack returned the cycle after issue, dropped the cycle after that).
- `done` is asserted the cycle after the final DRAIN exit, for exactly 1 cycle.
- Synchronous reset mid-program: the next edge returns all outputs to their reset values. The FU sees `on_off`=0.

## Configuration
- Macro: `FU_SEQ_TIMEOUT_EN`.
- Defined: a counter clears on entry to RUN and increments each RUN cycle with `ack`=0. When the count reaches `timeout_cycles`, the block sets `timeout_err`=1 (sticky), drives `on_off`←0, goes to IDLE, and does not pulse `done`.
- Undefined: no counter. RUN waits indefinitely, and `timeout_err` is tied to 0.

## Test plan
- Write mem[0..2]=16'h0000,16'h0005,16'h0007; `num_entries`=3, `start`. FU model acks 3 cycles after `on_off` rises. Required: `config_out` steps 0000→0005→0007, `pc` 0→1→2, one `done` pulse, `busy` low after.
- `num_entries`=0, `start` → `done` pulse next cycle, `on_off` never high.
- `loop_en`=1, 2 entries, 5 acks → `pc` sequence 0,1,0,1,0; no `done`. Then `stop` → IDLE next cycle, `on_off`=0.
- Hold `ack` high for 4 cycles after the first acknowledge → sequencer stays in DRAIN with `on_off`=0 until `ack` drops; entry 1 issues exactly one cycle later.
- With `FU_SEQ_TIMEOUT_EN`, `timeout_cycles`=8, `ack` tied 0 → `timeout_err`=1 after 8 RUN cycles, `on_off`=0, no `done`. The next `start` clears `timeout_err`.
- `cfg_we` while busy, then `reset` mid-RUN → the write is not visible in the next program; all outputs are 0 one cycle after reset.
